shift_reg_piso_tx: RTL and testbench
====================================

# shift_reg_piso_tx

Parallel-in, serial-out transmitter: the sending end of the team's serial shift-register link. It accepts a WIDTH-bit word through a ready/valid load handshake and drives the word onto a single serial line, MSB first, one bit per clock, with a data-valid strobe. A `Shift_Reg_Sync` receiver on the same clock, enabled by DVALID, holds the word in its DOUT[WIDTH-1:0] after WIDTH enabled edges. An optional even-parity bit can follow the data.

## Interface
- WIDTH, 4: data word width in bits; legal range 2..32.
- CLK  in  1  rising-edge clock; the only clock.
- nCLR  in  1  asynchronous, active-low reset.
- DIN  in  WIDTH  parallel word to transmit; sampled only on an accepted load.
- LOAD  in  1  load request (valid); held until accepted.
- READY  out  1  transmitter can accept a word this cycle.
- DOUT  out  1  serial data, MSB first.
- DVALID  out  1  DOUT carries a data bit (or the parity bit) this cycle.
- DONE  out  1  single-cycle pulse during the final serial bit of a frame.

## Operation
- States: IDLE, SHIFT, PAR (PAR exists only with SHIFT_REG_PISO_PARITY_EN).
- IDLE: READY=1, DVALID=0, DOUT=0. At a rising edge with LOAD=1: capture DIN into the internal shift register, set the bit counter to WIDTH-1, go to SHIFT.
- SHIFT: READY=0, DVALID=1, DOUT = shift register MSB. Each edge shifts left by one, fills the LSB with 0 and decrements the counter. When the counter is 0 on an edge: go to PAR if parity is enabled, otherwise go to IDLE.
- PAR: DVALID=1, DOUT = XOR of the captured word (even parity). The next edge goes to IDLE.
- DONE=1 during the last bit cycle of the frame: the count-0 SHIFT cycle without parity, or the PAR cycle with parity.
- LOAD while READY=0 is ignored. It does not queue and has no side effects. The requester keeps LOAD high until it sees READY=1.
- DIN changes outside the acceptance edge have no effect on a frame in flight.
- Bit counter width is clog2(WIDTH) and never wraps below 0. Parity is computed from the captured word, not from live DIN.
- Reset asserted at any time, including mid-frame: the frame is aborted immediately (asynchronously). The state goes to IDLE, the shift register and counter clear, and no DONE is issued.

## Timing
- Reset values: READY=1, DOUT=0, DVALID=0, DONE=0, state IDLE.
- Acceptance edge is E0. Data bit D[WIDTH-1-i] is on DOUT in the cycle after edge E0+i, for i = 0..WIDTH-1. The parity bit, when enabled, is on DOUT in the cycle after edge E0+WIDTH.
- All outputs are registered or decoded from registered state only. There are no combinational paths from LOAD or DIN to any output.
- READY returns to 1 in the cycle after the last bit cycle. The next acceptance can occur on the edge ending that READY=1 cycle, so there is exactly one idle cycle (DVALID=0) between frames.
- Frame period is WIDTH+1 cycles without parity and WIDTH+2 cycles with parity, counting from one acceptance edge to the earliest next acceptance edge.
- nCLR deassertion is seen at the next edge. LOAD=1 on that first edge is accepted.

## Configuration
- SHIFT_REG_PISO_PARITY_EN defined: the PAR state is present and one even-parity bit follows the data. DVALID stays high for WIDTH+1 cycles and DONE fires in the PAR cycle.
- SHIFT_REG_PISO_PARITY_EN undefined: no PAR state and no parity logic. The frame is exactly WIDTH bits and DONE fires in the last data-bit cycle.

## Structure
- Shared package shift_reg_pkg holds:
  - state encodings IDLE=2'd0, SHIFT=2'd1, PAR=2'd2;
  - the WIDTH legality bounds.
  - The future receiver-side blocks use the same package.
- One sub-module, shift_reg_bit_counter: a loadable down-counter with a terminal-count flag. The top level holds the FSM, the shift register and parity.

## Test plan
- Reset, then idle: READY=1, DOUT=0, DVALID=0, DONE=0, with LOAD held low for 10 cycles.
- WIDTH=4, DIN=4'b1011, LOAD pulsed 1 cycle: DOUT = 1,0,1,1 over the next 4 cycles with DVALID=1. DONE is high only in the 4th cycle. A DVALID-enabled `Shift_Reg_Sync` receiver on the same clock ends with DOUT=4'b1011.
- LOAD held high continuously with DIN=4'hA then 4'h5: two frames separated by exactly one DVALID=0 cycle. Bits are 1010 then 0101. LOAD during SHIFT does not restart the frame.
- Assert nCLR low during the 2nd bit of a frame: all outputs return to reset values without waiting for a clock edge, and no DONE is issued. After release, a new word DIN=4'hF transmits 1111 cleanly.
- SHIFT_REG_PISO_PARITY_EN defined, DIN=4'b0111: DOUT = 0,1,1,1,1 (parity 1) with DVALID high for 5 cycles and DONE in the 5th. With DIN=4'b0101 the parity bit is 0.
- WIDTH=8, DIN=8'h81: DOUT = 1,0,0,0,0,0,0,1. READY stays low for 8 cycles and rises in the 9th.

Source files
------------

// File: rtl/shift_reg_pkg.sv
// Shared definitions for the shift-register serial link (transmitter and future receiver blocks).
package shift_reg_pkg;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] SHIFT = 2'd1;
    localparam logic [1:0] PAR   = 2'd2;

    localparam int WIDTH_MIN = 2;
    localparam int WIDTH_MAX = 32;

endpackage

// File: rtl/shift_reg_piso_tx_if.sv
// Load handshake and serial output bundle of the PISO transmitter.
interface shift_reg_piso_tx_if #(
    parameter int WIDTH = 4
);
    logic [WIDTH-1:0] DIN;
    logic             LOAD;
    logic             READY;
    logic             DOUT;
    logic             DVALID;
    logic             DONE;

    modport master (
        output DIN, LOAD,
        input  READY, DOUT, DVALID, DONE
    );

    modport slave (
        input  DIN, LOAD,
        output READY, DOUT, DVALID, DONE
    );
endinterface

// File: rtl/shift_reg_bit_counter.sv
// Loadable down-counter with terminal-count flag; holds at zero instead of wrapping.
module shift_reg_bit_counter #(
    parameter int CNT_W = 2
) (
    input  logic             CLK,
    input  logic             nCLR,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             dec,
    output logic             tc
);
    logic [CNT_W-1:0] cnt;

    always_ff @(posedge CLK or negedge nCLR) begin
        if (!nCLR) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (dec && (cnt != '0)) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign tc = (cnt == '0);
endmodule

// File: rtl/shift_reg_piso_tx.sv
// Parallel-in serial-out transmitter, MSB first, with ready/valid load handshake.
// Define SHIFT_REG_PISO_PARITY_EN to append one even-parity bit after the data.
module shift_reg_piso_tx
    import shift_reg_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic               CLK,
    input  logic               nCLR,
    shift_reg_piso_tx_if.slave bus
);
    localparam int CNT_W = $clog2(WIDTH);

    if (WIDTH < WIDTH_MIN || WIDTH > WIDTH_MAX) begin : g_bad_width
        $error("shift_reg_piso_tx: WIDTH out of range");
    end

    logic [1:0]       state;
    logic [WIDTH-1:0] shreg;
    logic             cnt_tc;
    logic             accept;
    logic             shifting;

    assign accept   = (state == IDLE) && bus.LOAD;
    assign shifting = (state == SHIFT);

    shift_reg_bit_counter #(
        .CNT_W (CNT_W)
    ) u_bit_cnt (
        .CLK      (CLK),
        .nCLR     (nCLR),
        .load     (accept),
        .load_val (CNT_W'(WIDTH - 1)),
        .dec      (shifting),
        .tc       (cnt_tc)
    );

    always_ff @(posedge CLK or negedge nCLR) begin
        if (!nCLR) begin
            state <= IDLE;
            shreg <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.LOAD) begin
                        state <= SHIFT;
                        shreg <= bus.DIN;
                    end
                end
                SHIFT: begin
                    shreg <= {shreg[WIDTH-2:0], 1'b0};
                    if (cnt_tc) begin
`ifdef SHIFT_REG_PISO_PARITY_EN
                        state <= PAR;
`else
                        state <= IDLE;
`endif
                    end
                end
`ifdef SHIFT_REG_PISO_PARITY_EN
                PAR:     state <= IDLE;
`endif
                default: state <= IDLE;
            endcase
        end
    end

`ifdef SHIFT_REG_PISO_PARITY_EN
    // Parity latched at acceptance so live DIN never leaks into the frame.
    logic par_q;

    always_ff @(posedge CLK or negedge nCLR) begin
        if (!nCLR) begin
            par_q <= 1'b0;
        end else if (accept) begin
            par_q <= ^bus.DIN;
        end
    end

    assign bus.DOUT   = shifting ? shreg[WIDTH-1] : ((state == PAR) && par_q);
    assign bus.DVALID = shifting || (state == PAR);
    assign bus.DONE   = (state == PAR);
`else
    assign bus.DOUT   = shifting && shreg[WIDTH-1];
    assign bus.DVALID = shifting;
    assign bus.DONE   = shifting && cnt_tc;
`endif

    assign bus.READY = (state == IDLE);
endmodule

// File: tb/tb_shift_reg_piso_tx.sv
// Directed bench for shift_reg_piso_tx: WIDTH=4 and WIDTH=8 instances, optional parity build.
module tb_shift_reg_piso_tx;

`ifdef SHIFT_REG_PISO_PARITY_EN
    localparam int FL4 = 5;
    localparam int FL8 = 9;
    localparam logic [10:0] B2B_DV = 11'b11111_0_11111;
    localparam logic [10:0] B2B_DO = 11'b10100_0_01010;
    localparam logic [10:0] B2B_DN = 11'b00001_0_00001;
`else
    localparam int FL4 = 4;
    localparam int FL8 = 8;
    localparam logic [8:0] B2B_DV = 9'b1111_0_1111;
    localparam logic [8:0] B2B_DO = 9'b1010_0_0101;
    localparam logic [8:0] B2B_DN = 9'b0001_0_0001;
`endif
    localparam int NB = 2 * FL4 + 1;

    logic clk = 1'b0;
    logic nclr;
    always #5 clk = ~clk;

    shift_reg_piso_tx_if #(.WIDTH(4)) bus4 ();
    shift_reg_piso_tx_if #(.WIDTH(8)) bus8 ();

    shift_reg_piso_tx #(.WIDTH(4)) dut4 (.CLK(clk), .nCLR(nclr), .bus(bus4));
    shift_reg_piso_tx #(.WIDTH(8)) dut8 (.CLK(clk), .nCLR(nclr), .bus(bus8));

    // Shift_Reg_Sync receiver models, enabled by DVALID.
    logic [3:0] rx4;
    logic [7:0] rx8;
    always @(posedge clk or negedge nclr) begin
        if (!nclr) begin
            rx4 <= '0;
            rx8 <= '0;
        end else begin
            if (bus4.DVALID) rx4 <= {rx4[2:0], bus4.DOUT};
            if (bus8.DVALID) rx8 <= {rx8[6:0], bus8.DOUT};
        end
    end

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    typedef struct {
        logic [3:0] din;
        logic [3:0] seq;
        logic       par;
        string      nm;
    } vec_t;

    // Called at a negedge; pulses LOAD for one cycle and checks the whole frame.
    task automatic frame4(input logic [3:0] din, input logic [3:0] seq, input logic par,
                          input string nm);
        int guard = 0;
        logic exp_do;
        while (!bus4.READY && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        chk({nm, "_ready"}, 32'(bus4.READY), 32'd1);
        bus4.DIN  = din;
        bus4.LOAD = 1'b1;
        @(posedge clk);
        #1;
        bus4.LOAD = 1'b0;
        bus4.DIN  = ~din;
        for (int i = 0; i < FL4; i++) begin
            @(negedge clk);
            exp_do = (i < 4) ? seq[3-i] : par;
            chk({nm, "_dout"},   32'(bus4.DOUT),   32'(exp_do));
            chk({nm, "_dvalid"}, 32'(bus4.DVALID), 32'd1);
            chk({nm, "_rdy_lo"}, 32'(bus4.READY),  32'd0);
            chk({nm, "_done"},   32'(bus4.DONE),   32'(i == FL4 - 1));
        end
        @(negedge clk);
        chk({nm, "_idle_rdy"}, 32'(bus4.READY),  32'd1);
        chk({nm, "_idle_dv"},  32'(bus4.DVALID), 32'd0);
        chk({nm, "_idle_dn"},  32'(bus4.DONE),   32'd0);
`ifndef SHIFT_REG_PISO_PARITY_EN
        chk({nm, "_rx"}, 32'(rx4), 32'(seq));
`endif
    endtask

    vec_t vecs[8];

    initial begin
        vecs[0] = '{4'b1011, 4'b1011, 1'b1, "v1011"};
        vecs[1] = '{4'hA,    4'b1010, 1'b0, "vA"};
        vecs[2] = '{4'h5,    4'b0101, 1'b0, "v5"};
        vecs[3] = '{4'b0111, 4'b0111, 1'b1, "v0111"};
        vecs[4] = '{4'b0101, 4'b0101, 1'b0, "v0101"};
        vecs[5] = '{4'h0,    4'b0000, 1'b0, "v0"};
        vecs[6] = '{4'h8,    4'b1000, 1'b1, "v8"};
        vecs[7] = '{4'h6,    4'b0110, 1'b0, "v6"};

        nclr      = 1'b0;
        bus4.DIN  = '0;
        bus4.LOAD = 1'b0;
        bus8.DIN  = '0;
        bus8.LOAD = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_ready",  32'(bus4.READY),  32'd1);
        chk("rst_dout",   32'(bus4.DOUT),   32'd0);
        chk("rst_dvalid", 32'(bus4.DVALID), 32'd0);
        chk("rst_done",   32'(bus4.DONE),   32'd0);
        nclr = 1'b1;

        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            chk("idle_ready",  32'(bus4.READY),  32'd1);
            chk("idle_dout",   32'(bus4.DOUT),   32'd0);
            chk("idle_dvalid", 32'(bus4.DVALID), 32'd0);
            chk("idle_done",   32'(bus4.DONE),   32'd0);
        end

        for (int v = 0; v < 8; v++) begin
            frame4(vecs[v].din, vecs[v].seq, vecs[v].par, vecs[v].nm);
        end

        // LOAD held high across two frames: A then 5, one idle cycle between.
        bus4.DIN  = 4'hA;
        bus4.LOAD = 1'b1;
        @(posedge clk);
        #1;
        bus4.DIN = 4'h5;
        for (int c = 0; c < NB; c++) begin
            @(negedge clk);
            chk("b2b_dvalid", 32'(bus4.DVALID), 32'(B2B_DV[NB-1-c]));
            chk("b2b_dout",   32'(bus4.DOUT),   32'(B2B_DO[NB-1-c]));
            chk("b2b_done",   32'(bus4.DONE),   32'(B2B_DN[NB-1-c]));
            if (c == FL4 + 1) bus4.LOAD = 1'b0;
        end
        @(negedge clk);
        chk("b2b_end_ready",  32'(bus4.READY),  32'd1);
        chk("b2b_end_dvalid", 32'(bus4.DVALID), 32'd0);

        // Asynchronous abort during the 2nd bit.
        bus4.DIN  = 4'b1011;
        bus4.LOAD = 1'b1;
        @(posedge clk);
        #1;
        bus4.LOAD = 1'b0;
        @(negedge clk);
        chk("abort_bit1", 32'(bus4.DOUT), 32'd1);
        @(posedge clk);
        #2;
        nclr = 1'b0;
        #1;
        chk("abort_ready",  32'(bus4.READY),  32'd1);
        chk("abort_dout",   32'(bus4.DOUT),   32'd0);
        chk("abort_dvalid", 32'(bus4.DVALID), 32'd0);
        chk("abort_done",   32'(bus4.DONE),   32'd0);
        repeat (2) begin
            @(negedge clk);
            chk("abort_hold_done",   32'(bus4.DONE),   32'd0);
            chk("abort_hold_dvalid", 32'(bus4.DVALID), 32'd0);
        end
        nclr = 1'b1;
        frame4(4'hF, 4'b1111, 1'b0, "recover");

        // WIDTH=8, 8'h81.
        bus8.DIN  = 8'h81;
        bus8.LOAD = 1'b1;
        @(posedge clk);
        #1;
        bus8.LOAD = 1'b0;
        bus8.DIN  = 8'h00;
        for (int i = 0; i < FL8; i++) begin
            @(negedge clk);
            chk("w8_dout",   32'(bus8.DOUT),   32'((i == 0) || (i == 7)));
            chk("w8_dvalid", 32'(bus8.DVALID), 32'd1);
            chk("w8_ready",  32'(bus8.READY),  32'd0);
            chk("w8_done",   32'(bus8.DONE),   32'(i == FL8 - 1));
        end
        @(negedge clk);
        chk("w8_ready_up", 32'(bus8.READY),  32'd1);
        chk("w8_dv_down",  32'(bus8.DVALID), 32'd0);
`ifndef SHIFT_REG_PISO_PARITY_EN
        chk("w8_rx", 32'(rx8), 32'h81);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
